// File: rtl/sisc_fetch.sv
// Instruction fetch for sisc: owns the PC, runs one memory request at a time, and holds IR for decode.
// The branch redirect overrides a pending ACK or handshake in the same cycle.
module sisc_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST_F,
  output logic        IM_REQ,
  output logic [15:0] IM_ADDR,
  input  logic        IM_ACK,
  input  logic [31:0] IM_DATA,
  output logic [31:0] IR,
  output logic        IR_VALID,
  input  logic        IR_READY,
  output logic [15:0] PC_OUT,
  output logic [15:0] PC_INC,
  input  logic        BR_TAKEN,
  input  logic        BR_SEL,
  input  logic [15:0] BR_IMM,
  input  logic        HALT
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, STOP} state_t;

  state_t      state;
  logic [15:0] fetch_pc;
  logic [15:0] target;

  assign PC_INC   = PC_OUT + 16'd1;
  assign target   = BR_SEL ? BR_IMM : PC_INC + BR_IMM;
  assign IM_ADDR  = fetch_pc;
  // Decoded straight from the state flop so an async reset drops both at once.
  assign IM_REQ   = (state == FETCH);
  assign IR_VALID = (state == HOLD);

  always_ff @(posedge CLK or posedge RST_F) begin
    if (RST_F) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      IR       <= 32'd0;
      PC_OUT   <= 16'd0;
    end else if (state == STOP) begin
      if (BR_TAKEN) begin
        fetch_pc <= target;
      end else if (!HALT) begin
        state <= FETCH;
      end
    end else if (BR_TAKEN) begin
      fetch_pc <= target;
      state    <= HALT ? STOP : FETCH;
    end else begin
      case (state)
        IDLE: state <= HALT ? STOP : FETCH;
        FETCH: begin
          if (IM_ACK) begin
            IR       <= IM_DATA;
            PC_OUT   <= fetch_pc;
            fetch_pc <= fetch_pc + 16'd1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (IR_READY) state <= HALT ? STOP : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: directed vector table, hand-built corner sequences, then random traffic against a model.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        ack, rdy, br, sel, halt;
  logic [31:0] data;
  logic [15:0] imm;

  logic        req, vld;
  logic [15:0] addr, pc_out, pc_inc;
  logic [31:0] ir;
  logic        w_req, w_vld;
  logic [15:0] w_addr, w_pc_out, w_pc_inc;
  logic [31:0] w_ir;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sisc_fetch #(.RESET_PC(16'h0000)) dut (
    .CLK(clk), .RST_F(rst_f), .IM_REQ(req), .IM_ADDR(addr), .IM_ACK(ack),
    .IM_DATA(data), .IR(ir), .IR_VALID(vld), .IR_READY(rdy), .PC_OUT(pc_out),
    .PC_INC(pc_inc), .BR_TAKEN(br), .BR_SEL(sel), .BR_IMM(imm), .HALT(halt)
  );

  sisc_fetch #(.RESET_PC(16'hFFFF)) dut_w (
    .CLK(clk), .RST_F(rst_f), .IM_REQ(w_req), .IM_ADDR(w_addr), .IM_ACK(ack),
    .IM_DATA(data), .IR(w_ir), .IR_VALID(w_vld), .IR_READY(rdy), .PC_OUT(w_pc_out),
    .PC_INC(w_pc_inc), .BR_TAKEN(br), .BR_SEL(sel), .BR_IMM(imm), .HALT(halt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ack = 0; rdy = 0; br = 0; sel = 0; halt = 0; data = '0; imm = '0;
  endtask

  // Leaves the DUTs in their first IDLE cycle, sampled at a falling edge.
  task automatic do_reset();
    rst_f = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_f = 1'b0;
  endtask

  typedef struct {
    logic        br;
    logic        sel;
    logic [15:0] imm;
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic        req;
    logic        vld;
    logic [15:0] addr;
    logic [31:0] ir;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[14];

  // Reference model state: what the fetch stage is doing, in plain terms.
  bit          m_req, m_vld, m_stop;
  logic [15:0] m_fpc, m_pcout;
  logic [31:0] m_ir;

  task automatic model_reset();
    m_req = 0; m_vld = 0; m_stop = 0;
    m_fpc = 16'h0000; m_pcout = 16'h0000; m_ir = 32'h0;
  endtask

  task automatic model_step();
    logic [15:0] tgt;
    logic [15:0] nxt;
    nxt = m_pcout + 16'd1;
    tgt = sel ? imm : 16'(nxt + imm);
    if (m_stop) begin
      if (br) m_fpc = tgt;
      else if (!halt) begin m_stop = 0; m_req = 1; end
    end else if (br) begin
      m_fpc = tgt; m_vld = 0; m_req = !halt; m_stop = halt;
    end else if (m_req) begin
      if (ack) begin
        m_ir = data; m_pcout = m_fpc; m_fpc = m_fpc + 16'd1;
        m_req = 0; m_vld = 1;
      end
    end else if (m_vld) begin
      if (rdy) begin m_vld = 0; m_req = !halt; m_stop = halt; end
    end else begin
      m_req = !halt; m_stop = halt;
    end
  endtask

  initial begin
    //          br  sel  imm       ack  data           rdy  req vld addr      ir             pc
    tbl[0]  = '{0, 0, 16'h0000, 0, 32'h0,        0, 0, 0, 16'h0000, 32'h0,        16'h0000};
    tbl[1]  = '{0, 0, 16'h0000, 1, 32'h11111111, 1, 1, 0, 16'h0000, 32'h0,        16'h0000};
    tbl[2]  = '{0, 0, 16'h0000, 0, 32'h0,        1, 0, 1, 16'h0001, 32'h11111111, 16'h0000};
    tbl[3]  = '{0, 0, 16'h0000, 1, 32'h22222222, 1, 1, 0, 16'h0001, 32'h11111111, 16'h0000};
    tbl[4]  = '{0, 0, 16'h0000, 0, 32'h0,        1, 0, 1, 16'h0002, 32'h22222222, 16'h0001};
    tbl[5]  = '{0, 0, 16'h0000, 1, 32'h33333333, 1, 1, 0, 16'h0002, 32'h22222222, 16'h0001};
    tbl[6]  = '{0, 0, 16'h0000, 0, 32'h0,        0, 0, 1, 16'h0003, 32'h33333333, 16'h0002};
    tbl[7]  = '{0, 0, 16'h0000, 0, 32'h0,        0, 0, 1, 16'h0003, 32'h33333333, 16'h0002};
    tbl[8]  = '{1, 1, 16'h0010, 0, 32'h0,        0, 0, 1, 16'h0003, 32'h33333333, 16'h0002};
    tbl[9]  = '{0, 0, 16'h0000, 1, 32'h44444444, 0, 1, 0, 16'h0010, 32'h33333333, 16'h0002};
    tbl[10] = '{1, 0, 16'hFFFE, 0, 32'h0,        1, 0, 1, 16'h0011, 32'h44444444, 16'h0010};
    tbl[11] = '{1, 1, 16'h0040, 1, 32'h55555555, 0, 1, 0, 16'h000F, 32'h44444444, 16'h0010};
    tbl[12] = '{0, 0, 16'h0000, 1, 32'h66666666, 0, 1, 0, 16'h0040, 32'h44444444, 16'h0010};
    tbl[13] = '{0, 0, 16'h0000, 0, 32'h0,        0, 0, 1, 16'h0041, 32'h66666666, 16'h0040};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("tbl%0d.req", i), {31'd0, req}, {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d.vld", i), {31'd0, vld}, {31'd0, tbl[i].vld});
      chk($sformatf("tbl%0d.addr", i), {16'd0, addr}, {16'd0, tbl[i].addr});
      chk($sformatf("tbl%0d.ir", i), ir, tbl[i].ir);
      chk($sformatf("tbl%0d.pc_out", i), {16'd0, pc_out}, {16'd0, tbl[i].pc});
      chk($sformatf("tbl%0d.pc_inc", i), {16'd0, pc_inc}, {16'd0, 16'(tbl[i].pc + 16'd1)});
      br = tbl[i].br; sel = tbl[i].sel; imm = tbl[i].imm;
      ack = tbl[i].ack; data = tbl[i].data; rdy = tbl[i].rdy;
      @(negedge clk);
    end

    // Memory wait states at address 5, reached by an absolute branch taken in IDLE.
    do_reset();
    br = 1; sel = 1; imm = 16'h0005;
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("wait.req", {31'd0, req}, 32'd1);
      chk("wait.addr", {16'd0, addr}, 32'h5);
      chk("wait.vld", {31'd0, vld}, 32'd0);
      @(negedge clk);
    end
    chk("ack.addr", {16'd0, addr}, 32'h5);
    ack = 1; data = 32'hA5A50005;
    @(negedge clk);
    ack = 0;
    chk("ack.vld", {31'd0, vld}, 32'd1);
    chk("ack.ir", ir, 32'hA5A50005);
    chk("ack.pc_out", {16'd0, pc_out}, 32'h5);

    // Decode stalls for four cycles.
    for (int i = 0; i < 4; i++) begin
      chk("stall.vld", {31'd0, vld}, 32'd1);
      chk("stall.req", {31'd0, req}, 32'd0);
      chk("stall.ir", ir, 32'hA5A50005);
      @(negedge clk);
    end
    rdy = 1;
    @(negedge clk);
    rdy = 0;
    chk("stall_end.req", {31'd0, req}, 32'd1);
    chk("stall_end.vld", {31'd0, vld}, 32'd0);
    chk("stall_end.addr", {16'd0, addr}, 32'h6);

    // HALT raised while IR is held, then released.
    ack = 1; data = 32'hCAFE0006;
    @(negedge clk);
    ack = 0; halt = 1;
    chk("halt.hold_vld", {31'd0, vld}, 32'd1);
    @(negedge clk);
    rdy = 1;
    @(negedge clk);
    rdy = 0;
    chk("halt.stop_req", {31'd0, req}, 32'd0);
    chk("halt.stop_vld", {31'd0, vld}, 32'd0);
    @(negedge clk);
    chk("halt.still_stop", {31'd0, req}, 32'd0);
    chk("halt.addr", {16'd0, addr}, 32'h7);
    halt = 0;
    @(negedge clk);
    chk("resume.req", {31'd0, req}, 32'd1);
    chk("resume.addr", {16'd0, addr}, 32'h7);

    // Reset pulsed between edges during FETCH.
    #2 rst_f = 1;
    #1;
    chk("areset.req", {31'd0, req}, 32'd0);
    chk("areset.vld", {31'd0, vld}, 32'd0);
    chk("areset.addr", {16'd0, addr}, 32'h0);
    chk("areset.ir", ir, 32'h0);
    chk("areset.pc_inc", {16'd0, pc_inc}, 32'h1);
    chk("areset.w_addr", {16'd0, w_addr}, 32'hFFFF);
    @(negedge clk);
    rst_f = 0;

    // PC wrap on the instance that resets to 16'hFFFF.
    @(negedge clk);
    chk("wrap.req", {31'd0, w_req}, 32'd1);
    chk("wrap.addr0", {16'd0, w_addr}, 32'hFFFF);
    ack = 1; data = 32'h0BADF00D;
    @(negedge clk);
    ack = 0; rdy = 1;
    chk("wrap.pc_out", {16'd0, w_pc_out}, 32'hFFFF);
    chk("wrap.pc_inc", {16'd0, w_pc_inc}, 32'h0);
    chk("wrap.ir", w_ir, 32'h0BADF00D);
    @(negedge clk);
    rdy = 0;
    chk("wrap.addr1", {16'd0, w_addr}, 32'h0);
    chk("wrap.req1", {31'd0, w_req}, 32'd1);

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      chk("rnd.req", {31'd0, req}, {31'd0, m_req});
      chk("rnd.vld", {31'd0, vld}, {31'd0, m_vld});
      chk("rnd.addr", {16'd0, addr}, {16'd0, m_fpc});
      chk("rnd.ir", ir, m_ir);
      chk("rnd.pc_out", {16'd0, pc_out}, {16'd0, m_pcout});
      chk("rnd.pc_inc", {16'd0, pc_inc}, {16'd0, 16'(m_pcout + 16'd1)});
      chk("rnd.exclusive", {31'd0, req & vld}, 32'd0);
      ack  = ($urandom_range(0, 2) == 0);
      rdy  = $urandom_range(0, 1) == 1;
      br   = ($urandom_range(0, 7) == 0);
      sel  = $urandom_range(0, 1) == 1;
      imm  = 16'($urandom);
      data = $urandom;
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
